// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch command generator: FSM states, command
// encoding and the command-to-strobe decoder.
package stopwatch_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    TICK  = 3'd1,
    START = 3'd2,
    STOP  = 3'd3,
    RESET = 3'd4
  } cmd_e;

  // Strobe order is {do_reset, do_stop, do_start, do_tick}
  function automatic logic [3:0] cmd_decode(input cmd_e cmd);
    logic [3:0] strobes;
    strobes = 4'b0000;
    case (cmd)
      TICK:    strobes = 4'b0001;
      START:   strobes = 4'b0010;
      STOP:    strobes = 4'b0100;
      RESET:   strobes = 4'b1000;
      default: strobes = 4'b0000;
    endcase
    return strobes;
  endfunction

endpackage

// File: rtl/stopwatch_cmd_gen_if.sv
// Button inputs, stopwatch feedback and command strobes of stopwatch_cmd_gen.
// master drives buttons/feedback; slave is the command generator.
interface stopwatch_cmd_gen_if;
  logic        btn_start_stop;
  logic        btn_reset;
  logic        sw_running;
  logic        do_tick;
  logic        do_start;
  logic        do_stop;
  logic        do_reset;
  logic [31:0] tick_cnt;

  modport master (
    output btn_start_stop, btn_reset, sw_running,
    input  do_tick, do_start, do_stop, do_reset, tick_cnt
  );

  modport slave (
    input  btn_start_stop, btn_reset, sw_running,
    output do_tick, do_start, do_stop, do_reset, tick_cnt
  );
endinterface

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> optional debounce filter -> rising-edge press.
// The filter is built only when STOPWATCH_CMD_GEN_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic filt;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef STOPWATCH_CMD_GEN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counts consecutive samples that disagree with the accepted level
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d  = '0;
      filt_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_dbc;
  assign unused_dbc = |DEBOUNCE_CYCLES;
  assign filt       = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= filt;
  end

  assign press_o = filt & ~prev_q;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Stopwatch command generator: debounced buttons and a tick prescaler drive a
// STOPPED/RUNNING FSM issuing one-hot registered command strobes.
// Define STOPWATCH_CMD_GEN_DEBOUNCE_EN to enable the button debounce filter.
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_cmd_gen_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);

  logic          ss_press, rst_press;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   tick_cnt_q, tick_cnt_d;
  cmd_e          cmd_d;
  logic [3:0]    do_q;
  logic          resync;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_start_stop),
    .press_o (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_reset),
    .press_o (rst_press)
  );

  // Follow the stopwatch only when no command of ours can still be in flight
  assign resync = (do_q == 4'b0000) &&
                  (((state_q == STOPPED) &&  bus.sw_running) ||
                   ((state_q == RUNNING) && !bus.sw_running));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    cmd_d      = NONE;
    if (rst_press) begin
      cmd_d      = RESET;
      state_d    = STOPPED;
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if (ss_press) begin
      presc_d = '0;
      if (state_q == STOPPED) begin
        cmd_d   = START;
        state_d = RUNNING;
      end else begin
        cmd_d   = STOP;
        state_d = STOPPED;
      end
    end else if (resync) begin
      state_d = bus.sw_running ? RUNNING : STOPPED;
      presc_d = '0;
    end else if (state_q == RUNNING) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d    = '0;
        cmd_d      = TICK;
        tick_cnt_d = tick_cnt_q + 32'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= STOPPED;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      do_q       <= 4'b0000;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      do_q       <= cmd_decode(cmd_d);
    end
  end

  assign bus.do_tick  = do_q[0];
  assign bus.do_start = do_q[1];
  assign bus.do_stop  = do_q[2];
  assign bus.do_reset = do_q[3];
  assign bus.tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Directed bench for stopwatch_cmd_gen (TICK_DIV=4, DEBOUNCE_CYCLES=3) with a
// small stopwatch model that feeds sw_running back from the command strobes.
module tb_stopwatch_cmd_gen;

`ifdef STOPWATCH_CMD_GEN_DEBOUNCE_EN
  localparam int DBL = 3;
`else
  localparam int DBL = 0;
`endif
  localparam int LAT = 3 + DBL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_model = 1'b0;
  logic sw_force_en = 1'b0;
  logic sw_force_val = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_tick  = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_reset = 0;
  int onehot_viol = 0;

  stopwatch_cmd_gen_if bus ();

  stopwatch_cmd_gen #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.sw_running = sw_force_en ? sw_force_val : sw_model;

  initial forever #5 clk = ~clk;

  function automatic logic [3:0] cur_outs();
    return {bus.do_reset, bus.do_stop, bus.do_start, bus.do_tick};
  endfunction

  // Pulse counters and stopwatch model, updated just after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (bus.do_tick)  n_tick++;
    if (bus.do_start) n_start++;
    if (bus.do_stop)  n_stop++;
    if (bus.do_reset) n_reset++;
    if ($countones(cur_outs()) > 1) onehot_viol++;
    if (!rst_n)                           sw_model = 1'b0;
    else if (bus.do_start)                sw_model = 1'b1;
    else if (bus.do_stop || bus.do_reset) sw_model = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Steps until the selected strobe shows; n=40 means it never came
  task automatic wait_pulse(input int sel, output int n);
    logic [3:0] o;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      n++;
      o = cur_outs();
      if (o[sel]) return;
    end
  endtask

  initial begin
    int n, s0, t0, p0, steps, tc, k;
    bus.btn_start_stop = 1'b0;
    bus.btn_reset      = 1'b0;

    // Reset state and first clock after release
    step(3);
    chk("rst_outs", 32'(cur_outs()), 0);
    chk("rst_tick_cnt", bus.tick_cnt, 0);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_outs", 32'(cur_outs()), 0);

    // Held start press, then ticks every 4 clocks
    s0 = n_start; t0 = n_tick;
    bus.btn_start_stop = 1'b1;
    wait_pulse(1, n);
    chk("start_lat", n, LAT);
    step(4);
    chk("tick1", 32'(bus.do_tick), 1);
    chk("tick_cnt1", bus.tick_cnt, 1);
    bus.btn_start_stop = 1'b0;
    step(4);
    chk("tick_cnt2", bus.tick_cnt, 2);
    step(4);
    chk("tick3", 32'(bus.do_tick), 1);
    chk("tick_cnt3", bus.tick_cnt, 3);
    chk("start_once", n_start - s0, 1);
    chk("tick_count", n_tick - t0, 3);

    // Stop landing on a tick cycle drops the tick
    steps = (4 - (LAT % 4)) % 4;
    tc = 3 + (steps + LAT - 1) / 4;
    step(steps);
    bus.btn_start_stop = 1'b1;
    step(LAT - 1);
    chk("pre_stop_cnt", bus.tick_cnt, tc);
    step(1);
    chk("stop_pulse", 32'(bus.do_stop), 1);
    chk("stop_no_tick", 32'(bus.do_tick), 0);
    chk("stop_cnt_same", bus.tick_cnt, tc);
    bus.btn_start_stop = 1'b0;
    t0 = n_tick;
    step(10);
    chk("stopped_no_tick", n_tick - t0, 0);

    // Simultaneous reset + start_stop while running at tick_cnt=7
    bus.btn_start_stop = 1'b1;
    wait_pulse(1, n);
    chk("restart_lat", n, LAT);
    bus.btn_start_stop = 1'b0;
    k = 4 * (7 - tc) + 1 - LAT;
    step(k);
    bus.btn_start_stop = 1'b1;
    bus.btn_reset      = 1'b1;
    s0 = n_start; p0 = n_stop;
    step(LAT - 1);
    chk("cnt_at_7", bus.tick_cnt, 7);
    step(1);
    chk("dual_reset", 32'(cur_outs()), 32'h8);
    chk("dual_cnt0", bus.tick_cnt, 0);
    bus.btn_start_stop = 1'b0;
    bus.btn_reset      = 1'b0;
    t0 = n_tick;
    step(10);
    chk("dual_no_start", (n_start - s0) + (n_stop - p0), 0);
    chk("dual_stopped", n_tick - t0, 0);

    // Bouncing start_stop then stable high
    s0 = n_start; p0 = n_stop;
    bus.btn_start_stop = 1'b1; step(1);
    bus.btn_start_stop = 1'b0; step(1);
    bus.btn_start_stop = 1'b1; step(1);
    bus.btn_start_stop = 1'b0; step(1);
    bus.btn_start_stop = 1'b1;
    step(LAT - 1);
    chk("bounce_pulses", (n_start - s0) + (n_stop - p0), (DBL == 0) ? 2 : 0);
    step(1);
    chk("bounce_start", 32'(bus.do_start), 1);
    bus.btn_start_stop = 1'b0;
    step(10);

    // Reset press while running, then resync from sw_running
    bus.btn_reset = 1'b1;
    wait_pulse(3, n);
    chk("reset_lat", n, LAT);
    chk("reset_cnt0", bus.tick_cnt, 0);
    bus.btn_reset = 1'b0;
    step(10);
    s0 = n_start; t0 = n_tick;
    sw_force_val = 1'b1;
    sw_force_en  = 1'b1;
    step(4);
    chk("resync_wait", n_tick - t0, 0);
    step(1);
    chk("resync_tick", 32'(bus.do_tick), 1);
    chk("resync_cnt", bus.tick_cnt, 1);
    chk("resync_no_start", n_start - s0, 0);
    sw_force_val = 1'b0;
    t0 = n_tick;
    step(10);
    chk("resync_stop", n_tick - t0, 0);
    sw_force_en = 1'b0;

    // rst_n pulse in the middle of a held press's debounce
    s0 = n_start;
    bus.btn_start_stop = 1'b1;
    step(4);
    chk("pre_rst_press", n_start - s0, (DBL == 0) ? 1 : 0);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_outs", 32'(cur_outs()), 0);
    chk("mid_rst_cnt", bus.tick_cnt, 0);
    rst_n = 1'b1;
    s0 = n_start;
    step(LAT - 1);
    chk("no_early_press", n_start - s0, 0);
    step(1);
    chk("fresh_press", 32'(bus.do_start), 1);
    bus.btn_start_stop = 1'b0;
    step(2);

    chk("onehot", onehot_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
